// File: rtl/v12_filter_parameters.sv
// Constants and FSM state type shared by the peak detector and its event slot.
package v12_filter_parameters;
  localparam int SIZE    = 16;
  localparam int TIME_W  = 32;
  localparam int WIDTH_W = 8;
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    ABOVE = 2'd2
  } state_t;
endpackage

// File: rtl/v12_event_slot.sv
// Single-entry output record with valid/ready handshake and a saturating drop counter.
module v12_event_slot
  import v12_filter_parameters::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [SIZE-1:0]    load_amp,
  input  logic [TIME_W-1:0]  load_time,
  input  logic [WIDTH_W-1:0] load_width,
  input  logic               load_pileup,
  input  logic               event_ready,
  output logic               event_valid,
  output logic [SIZE-1:0]    event_amp,
  output logic [TIME_W-1:0]  event_time,
  output logic [WIDTH_W-1:0] event_width,
  output logic               event_pileup,
  output logic [7:0]         drop_count
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A held record that is not being taken this edge blocks the new one.
  logic blocked;
  assign blocked = event_valid && !event_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid  <= 1'b0;
      event_amp    <= '0;
      event_time   <= '0;
      event_width  <= '0;
      event_pileup <= 1'b0;
      drop_count   <= '0;
    end else if (load) begin
      if (blocked) begin
        drop_count <= sat_inc8(drop_count);
      end else begin
        event_valid  <= 1'b1;
        event_amp    <= load_amp;
        event_time   <= load_time;
        event_width  <= load_width;
        event_pileup <= load_pileup;
      end
    end else if (event_valid && event_ready) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/v12_peak_detector.sv
// Threshold pulse detector: tracks peak, width and start time of each pulse and
// hands completed pulses of at least MIN_WIDTH samples to the event slot.
module v12_peak_detector
  import v12_filter_parameters::*;
#(
  parameter int THRESHOLD = 100,
  parameter int MIN_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SIZE-1:0]    filter_data,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [SIZE-1:0]    event_amp,
  output logic [TIME_W-1:0]  event_time,
  output logic [WIDTH_W-1:0] event_width,
  output logic               event_pileup,
  output logic [7:0]         drop_count
);

  localparam logic [SIZE-1:0]    THRESH = SIZE'(THRESHOLD);
  localparam logic [WIDTH_W-1:0] MIN_W  = WIDTH_W'(MIN_WIDTH);

  function automatic logic [WIDTH_W-1:0] sat_inc_width(input logic [WIDTH_W-1:0] v);
    return (v == WIDTH_MAX) ? v : v + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   time_cnt;
  logic [TIME_W-1:0]   start_time;
  logic [SIZE-1:0]     peak;
  logic [WIDTH_W-1:0]  width;
  logic                above;
  logic                pulse_start, pulse_grow, pulse_done;
  logic                slot_load;

  assign above = filter_data > THRESH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARM:     if (!above) state_d = IDLE;
      IDLE:    if (above)  state_d = ABOVE;
      ABOVE:   if (!above) state_d = IDLE;
      default: state_d = ARM;
    endcase
  end

  always_comb begin
    pulse_start = (state_q == IDLE)  &&  above;
    pulse_grow  = (state_q == ABOVE) &&  above;
    pulse_done  = (state_q == ABOVE) && !above;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_cnt   <= '0;
      start_time <= '0;
      peak       <= '0;
      width      <= '0;
    end else begin
      time_cnt <= time_cnt + 1'b1;
      if (pulse_start) begin
        peak       <= filter_data;
        width      <= 1;
        start_time <= time_cnt;
      end else if (pulse_grow) begin
        if (filter_data > peak) peak <= filter_data;
        width <= sat_inc_width(width);
      end
    end
  end

  // Short pulses die here, before the slot, so they never count as drops.
  assign slot_load = pulse_done && (width >= MIN_W);

  v12_event_slot u_slot (
    .clk          (clk),
    .reset        (reset),
    .load         (slot_load),
    .load_amp     (peak),
    .load_time    (start_time),
    .load_width   (width),
    .load_pileup  (width == WIDTH_MAX),
    .event_ready  (event_ready),
    .event_valid  (event_valid),
    .event_amp    (event_amp),
    .event_time   (event_time),
    .event_width  (event_width),
    .event_pileup (event_pileup),
    .drop_count   (drop_count)
  );

endmodule

// File: tb/tb_v12_peak_detector.sv
// Bench for v12_peak_detector: directed vector table, hand-written corner sequences
// and random traffic compared against a run-based reference model.
module tb_v12_peak_detector;
  localparam int TH = 100;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] filter_data;
  logic        event_ready;
  logic        event_valid;
  logic [15:0] event_amp;
  logic [31:0] event_time;
  logic [7:0]  event_width;
  logic        event_pileup;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  v12_peak_detector #(.THRESHOLD(TH), .MIN_WIDTH(MW)) dut (
    .clk          (clk),
    .reset        (reset),
    .filter_data  (filter_data),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_amp    (event_amp),
    .event_time   (event_time),
    .event_width  (event_width),
    .event_pileup (event_pileup),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: collect the above-threshold run, summarise it when it ends.
  typedef struct { logic [15:0] s; logic [31:0] t; } smp_t;
  smp_t        run_q[$];
  bit          m_armed;
  logic [31:0] m_now;
  logic        m_valid;
  logic [15:0] m_amp;
  logic [31:0] m_time;
  logic [7:0]  m_width;
  logic        m_pileup;
  logic [7:0]  m_drop;

  task automatic model_reset();
    run_q.delete();
    m_armed = 0; m_now = 0; m_valid = 0; m_amp = 0; m_time = 0;
    m_width = 0; m_pileup = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic [15:0] d, input logic r);
    bit          done;
    int          len;
    logic [15:0] amp;
    logic [31:0] st;
    done = 0; len = 0; amp = 0; st = 0;
    if (!m_armed) begin
      if (d <= TH) m_armed = 1;
    end else if (d > TH) begin
      run_q.push_back('{s: d, t: m_now});
    end else if (run_q.size() > 0) begin
      done = 1;
      len  = run_q.size();
      foreach (run_q[i]) if (run_q[i].s > amp) amp = run_q[i].s;
      st = run_q[0].t;
      run_q.delete();
    end
    if (done && len >= MW) begin
      if (m_valid && !r) begin
        if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
      end else begin
        m_valid  = 1;
        m_amp    = amp;
        m_time   = st;
        m_width  = (len > 255) ? 8'd255 : 8'(len);
        m_pileup = (len >= 255);
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    m_now = m_now + 32'd1;
  endtask

  task automatic check_model();
    bit bad;
    checks++;
    bad = (event_valid !== m_valid) || (drop_count !== m_drop);
    if (m_valid && ((event_amp !== m_amp) || (event_time !== m_time) ||
                    (event_width !== m_width) || (event_pileup !== m_pileup)))
      bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL model_cmp t=%0t: valid %0b/%0b amp %0d/%0d time %0d/%0d width %0d/%0d pileup %0b/%0b drop %0d/%0d (got/expected)",
               $time, event_valid, m_valid, event_amp, m_amp, event_time, m_time,
               event_width, m_width, event_pileup, m_pileup, drop_count, m_drop);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic r);
    filter_data = d;
    event_ready = r;
    @(posedge clk);
    model_step(d, r);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset(input logic [15:0] d);
    filter_data = d;
    event_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_async_valid", {31'd0, event_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_val("rst_valid", {31'd0, event_valid}, 32'd0);
    check_val("rst_amp", {16'd0, event_amp}, 32'd0);
    check_val("rst_time", event_time, 32'd0);
    check_val("rst_width", {24'd0, event_width}, 32'd0);
    check_val("rst_pileup", {31'd0, event_pileup}, 32'd0);
    check_val("rst_drop", {24'd0, drop_count}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] amp, input int n, input logic r);
    for (int i = 0; i < n; i++) step(amp, r);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        r;
    logic        ev;
    logic [15:0] amp;
    logic [31:0] tm;
    logic [7:0]  wd;
    logic        pu;
    logic [7:0]  dr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    reset = 1'b1;
    filter_data = '0;
    event_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Basic pulse: first 150 sampled at time 5.
    vecs[0]  = '{16'd0,   1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[1]  = '{16'd0,   1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[2]  = '{16'd0,   1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[3]  = '{16'd0,   1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[4]  = '{16'd0,   1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[5]  = '{16'd150, 1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[6]  = '{16'd300, 1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[7]  = '{16'd500, 1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[8]  = '{16'd400, 1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[9]  = '{16'd200, 1'b0, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};
    vecs[10] = '{16'd50,  1'b0, 1'b1, 16'd500, 32'd5, 8'd5, 1'b0, 8'd0};
    vecs[11] = '{16'd0,   1'b0, 1'b1, 16'd500, 32'd5, 8'd5, 1'b0, 8'd0};
    vecs[12] = '{16'd0,   1'b1, 1'b0, 16'd0,   32'd0, 8'd0, 1'b0, 8'd0};

    do_reset(16'd0);
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].d, vecs[i].r);
      check_val($sformatf("vec%0d_valid", i), {31'd0, event_valid}, {31'd0, vecs[i].ev});
      check_val($sformatf("vec%0d_drop", i), {24'd0, drop_count}, {24'd0, vecs[i].dr});
      if (vecs[i].ev) begin
        check_val($sformatf("vec%0d_amp", i), {16'd0, event_amp}, {16'd0, vecs[i].amp});
        check_val($sformatf("vec%0d_time", i), event_time, vecs[i].tm);
        check_val($sformatf("vec%0d_width", i), {24'd0, event_width}, {24'd0, vecs[i].wd});
        check_val($sformatf("vec%0d_pileup", i), {31'd0, event_pileup}, {31'd0, vecs[i].pu});
      end
    end

    // Pulse already in progress at reset release is rejected.
    do_reset(16'd300);
    for (int i = 0; i < 10; i++) begin
      step(16'd300, 1'b0);
      check_val("arm_reject_valid", {31'd0, event_valid}, 32'd0);
    end
    step(16'd0, 1'b0);
    check_val("arm_reject_after", {31'd0, event_valid}, 32'd0);
    pulse(16'd200, 4, 1'b0);
    step(16'd0, 1'b0);
    check_val("arm_next_valid", {31'd0, event_valid}, 32'd1);
    check_val("arm_next_width", {24'd0, event_width}, 32'd4);
    check_val("arm_next_amp", {16'd0, event_amp}, 32'd200);
    step(16'd0, 1'b1);

    // Too-short pulse is discarded silently.
    pulse(16'd200, 3, 1'b1);
    step(16'd0, 1'b1);
    check_val("short_valid", {31'd0, event_valid}, 32'd0);
    check_val("short_drop", {24'd0, drop_count}, 32'd0);

    // Back-pressure: second event dropped, first record kept.
    pulse(16'd250, 4, 1'b0);
    step(16'd0, 1'b0);
    pulse(16'd260, 4, 1'b0);
    step(16'd0, 1'b0);
    check_val("bp_valid", {31'd0, event_valid}, 32'd1);
    check_val("bp_amp_kept", {16'd0, event_amp}, 32'd250);
    check_val("bp_drop", {24'd0, drop_count}, 32'd1);
    step(16'd0, 1'b1);
    check_val("bp_release", {31'd0, event_valid}, 32'd0);

    // Completion on the same edge the held record is accepted.
    pulse(16'd270, 4, 1'b0);
    step(16'd0, 1'b0);
    pulse(16'd280, 4, 1'b0);
    step(16'd0, 1'b1);
    check_val("swap_valid", {31'd0, event_valid}, 32'd1);
    check_val("swap_amp", {16'd0, event_amp}, 32'd280);
    check_val("swap_drop", {24'd0, drop_count}, 32'd1);
    step(16'd0, 1'b1);

    // Back-to-back pulses with the consumer always ready.
    do_reset(16'd0);
    step(16'd0, 1'b1);
    pulse(16'd300, 4, 1'b1);
    step(16'd0, 1'b1);
    check_val("b2b_first_amp", {16'd0, event_amp}, 32'd300);
    pulse(16'd310, 4, 1'b1);
    step(16'd0, 1'b1);
    check_val("b2b_second_valid", {31'd0, event_valid}, 32'd1);
    check_val("b2b_second_amp", {16'd0, event_amp}, 32'd310);
    check_val("b2b_drop", {24'd0, drop_count}, 32'd0);

    // Width saturation / pileup.
    do_reset(16'd0);
    step(16'd0, 1'b0);
    pulse(16'd1000, 300, 1'b0);
    step(16'd0, 1'b0);
    check_val("pile_valid", {31'd0, event_valid}, 32'd1);
    check_val("pile_width", {24'd0, event_width}, 32'd255);
    check_val("pile_flag", {31'd0, event_pileup}, 32'd1);
    check_val("pile_amp", {16'd0, event_amp}, 32'd1000);
    check_val("pile_time", event_time, 32'd1);

    // Reset with an event pending, then reset mid-pulse.
    do_reset(16'd0);
    step(16'd0, 1'b0);
    pulse(16'd200, 3, 1'b0);
    do_reset(16'd200);
    pulse(16'd200, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(16'd0, 1'b0);
      check_val("midrst_no_event", {31'd0, event_valid}, 32'd0);
    end
    check_val("midrst_drop", {24'd0, drop_count}, 32'd0);

    // Random traffic against the model.
    begin
      bit hi;
      logic [15:0] d;
      hi = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 599) == 0) do_reset(16'($urandom_range(0, 400)));
        if ($urandom_range(0, 5) == 0) hi = !hi;
        case ($urandom_range(0, 9))
          0:       d = hi ? 16'd101 : 16'd100;
          default: d = hi ? 16'($urandom_range(101, 2000)) : 16'($urandom_range(0, 100));
        endcase
        step(d, 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v12_peak_detector.md
V12_PEAK_DETECTOR -- requirements
Module: v12_peak_detector

Interface
REQ-001 Parameter THRESHOLD, default 100, meaning: a sample strictly greater than this value is above threshold (unsigned compare).
REQ-002 Parameter MIN_WIDTH, default 4, meaning: the fewest above-threshold samples that still form a reportable pulse.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port filter_data  input  size (16)  shaped-filter output sample, unsigned, one new sample every clk.
REQ-006 Port event_valid  output  1  event record is valid.
REQ-007 Port event_ready  input  1  consumer accepts the record.
REQ-008 Port event_amp  output  size  pulse peak amplitude.
REQ-009 Port event_time  output  32  timestamp of the first above-threshold sample.
REQ-010 Port event_width  output  8  count of above-threshold samples, saturating.
REQ-011 Port event_pileup  output  1  width saturated at 255.
REQ-012 Port drop_count  output  8  number of lost events, saturating at 255.

Function
REQ-013 The block SHALL keep a 32-bit free-running time counter that increments every clk and wraps from 0xFFFFFFFF to 0.
REQ-014 The FSM SHALL have three states: ARM, IDLE and ABOVE.
REQ-015 ARM SHALL move to IDLE on a sample <= THRESHOLD; this rejects a pulse that is already in progress when reset is released.
REQ-016 IDLE SHALL move to ABOVE on a sample > THRESHOLD, and on the same edge load peak=sample, width=1 and start_time=time counter.
REQ-017 While in ABOVE, each sample > THRESHOLD SHALL update peak=max(peak, sample) and increment width, saturating at 255.
REQ-018 ABOVE SHALL return to IDLE on a sample <= THRESHOLD; that edge is the completion edge.
REQ-019 At the completion edge, if width >= MIN_WIDTH, the block SHALL load the event registers (amp=peak, time=start_time, width, pileup=(width==255)) and set event_valid, visible in the next cycle.
REQ-020 At the completion edge, if width < MIN_WIDTH, the pulse SHALL be discarded silently and drop_count SHALL be unchanged.
REQ-021 Once event_valid is set, it and all event_* outputs SHALL hold stable until an edge with event_valid=1 and event_ready=1, which clears event_valid.
REQ-022 If a completion coincides with event_valid=1 and event_ready=0, the new event SHALL be dropped, the held record kept, and drop_count incremented (saturating).
REQ-023 If a completion coincides with event_valid=1 and event_ready=1, the new record SHALL load, event_valid SHALL stay 1, and nothing is dropped.
REQ-024 The detector SHALL add no back-pressure: the FSM keeps running regardless of event_ready.

Reset
REQ-025 Asserting reset SHALL immediately force state=ARM and clear the time counter, peak, width, event_valid, event_amp, event_time, event_width, event_pileup and drop_count to 0.
REQ-026 Reset asserted mid-pulse or with an event pending SHALL discard that pulse and event without counting a drop.

Structure
REQ-027 The width constant size and the FSM state enum SHALL live in shared package v12_filter_parameters; THRESHOLD and MIN_WIDTH stay module parameters.
REQ-028 The output record register plus valid/ready/drop logic SHALL be a single sub-module v12_event_slot; the FSM and time counter stay in the top module.

Verification
REQ-029 Apply reset, then samples 0,0,150,300,500,400,200,50 (THRESHOLD=100, MIN_WIDTH=4), with the first 150 sampled at time=5 -> one event: amp=500, time=5, width=5, pileup=0, drop_count=0.
REQ-030 Release reset while filter_data=300 held for 10 clks, then 0 -> no event emitted; the next pulse 0,200x4,0 is reported with width=4.
REQ-031 Pulse 0,200,200,200,0 (width 3 < MIN_WIDTH) -> no event; drop_count stays 0.
REQ-032 Hold event_ready=0 and send two valid pulses -> first record held unchanged, drop_count=1; raise event_ready for one clk -> event_valid=0.
REQ-033 Hold event_ready=1 with completions on back-to-back edges -> both records seen in consecutive cycles, drop_count=0.
REQ-034 Hold filter_data=1000 for 300 clks, then 0 -> width=255, pileup=1, amp=1000; separately, assert reset mid-pulse -> event_valid=0 and no event after release.
